regfile_mp: RTL and testbench

Parametrised multi-port integer register file, successor to the single-write, dual-read 32x32 register file. It provides:

- NRD combinational read ports and two prioritised write ports.
- A hardwired-zero option for entry 0.
- A post-reset hardware clear sweep, so the array needs no reset flops.
- A per-entry scoreboard (busy bits) for pending-writeback tracking.

It sits between decode/issue (reads, reservations) and writeback (writes) of the pipelined core.

---
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: read ports, two write ports, scoreboard reservation and ready.
// AW is derived from DEPTH and must match the register file instance it connects to.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                 ready;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic                 we0;
  logic                 we1;
  logic [AW-1:0]        waddr0;
  logic [AW-1:0]        waddr1;
  logic [XLEN-1:0]      wdata0;
  logic [XLEN-1:0]      wdata1;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;

  modport master (
    input  ready, rdata, rbusy,
    output raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, rsv_valid, rsv_addr
  );

  modport slave (
    output ready, rdata, rbusy,
    input  raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, rsv_valid, rsv_addr
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sweep and per-entry busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIMIT = DEPTH[AW:0];

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_n;
  logic [AW-1:0]     idx, idx_n;
  logic [DEPTH-1:0]  busy, busy_n;
  logic [XLEN-1:0]   mem [DEPTH];
  logic              run;
  logic              wr0_ok, wr1_ok, rsv_ok;

  // In range and not the hardwired-zero entry.
  function automatic logic usable(input logic [AW-1:0] a);
    return ({1'b0, a} < LIMIT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run       = (state == RUN);
  assign bus.ready = run;

  assign wr1_ok = run && bus.we1 && usable(bus.waddr1);
  assign wr0_ok = run && bus.we0 && usable(bus.waddr0)
                  && !(bus.we1 && (bus.waddr1 == bus.waddr0));
  assign rsv_ok = run && bus.rsv_valid && usable(bus.rsv_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= '0;
      busy  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    busy_n  = busy;
    case (state)
      CLEAR: begin
        idx_n = idx + 1'b1;
        if (idx == AW'(DEPTH - 1)) begin
          state_n = RUN;
          idx_n   = '0;
        end
      end
      RUN: begin
        if (wr0_ok) busy_n[bus.waddr0] = 1'b0;
        if (wr1_ok) busy_n[bus.waddr1] = 1'b0;
        // Applied last so a new reservation supersedes a same-cycle writeback.
        if (rsv_ok) busy_n[bus.rsv_addr] = 1'b1;
      end
      default: begin
        state_n = CLEAR;
        idx_n   = '0;
      end
    endcase
  end

  // Array has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[idx] <= '0;
    end else begin
      if (wr0_ok) mem[bus.waddr0] <= bus.wdata0;
      if (wr1_ok) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      logic [AW-1:0] ra;
      ra = bus.raddr[k*AW +: AW];
      if (run && usable(ra)) begin
        bus.rdata[k*XLEN +: XLEN] = mem[ra];
        bus.rbusy[k]              = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr0_ok && (bus.waddr0 == ra)) begin
          bus.rdata[k*XLEN +: XLEN] = bus.wdata0;
          bus.rbusy[k]              = rsv_ok && (bus.rsv_addr == ra);
        end
        if (wr1_ok && (bus.waddr1 == ra)) begin
          bus.rdata[k*XLEN +: XLEN] = bus.wdata1;
          bus.rbusy[k]              = rsv_ok && (bus.rsv_addr == ra);
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp against a behavioural model of the register file.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD)) bus ();

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_mem [DEPTH];
  bit              m_busy [DEPTH];
  bit              m_ready;
  int              m_cnt;

  function automatic bit ok_addr(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && (a != 0);
  endfunction

  function automatic bit acc0();
    return m_ready && bus.we0 && ok_addr(bus.waddr0) && !(bus.we1 && bus.waddr1 == bus.waddr0);
  endfunction

  function automatic bit acc1();
    return m_ready && bus.we1 && ok_addr(bus.waddr1);
  endfunction

  function automatic bit accr();
    return m_ready && bus.rsv_valid && ok_addr(bus.rsv_addr);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int k);
    logic [AW-1:0] a;
    a = bus.raddr[k*AW +: AW];
    if (!m_ready || !ok_addr(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (acc1() && bus.waddr1 == a) return bus.wdata1;
    if (acc0() && bus.waddr0 == a) return bus.wdata0;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(input int k);
    logic [AW-1:0] a;
    a = bus.raddr[k*AW +: AW];
    if (!m_ready || !ok_addr(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((acc1() && bus.waddr1 == a) || (acc0() && bus.waddr0 == a))
      return accr() && bus.rsv_addr == a;
`endif
    return m_busy[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    chk({tag, "_ready"}, bus.ready, m_ready);
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("%s_rdata%0d", tag, k), bus.rdata[k*XLEN +: XLEN], exp_rd(k));
      chk($sformatf("%s_rbusy%0d", tag, k), bus.rbusy[k], exp_rb(k));
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
  endtask

  task automatic tick();
    bit c0, c1, cr;
    logic [AW-1:0] a0, a1, ar;
    logic [XLEN-1:0] d0, d1;
    c0 = acc0(); c1 = acc1(); cr = accr();
    a0 = bus.waddr0; a1 = bus.waddr1; ar = bus.rsv_addr;
    d0 = bus.wdata0; d1 = bus.wdata1;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      if (c0) begin m_mem[a0] = d0; m_busy[a0] = 1'b0; end
      if (c1) begin m_mem[a1] = d1; m_busy[a1] = 1'b0; end
      if (cr) m_busy[ar] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.we1 = 1'b0; bus.rsv_valid = 1'b0;
    bus.waddr0 = '0; bus.waddr1 = '0; bus.rsv_addr = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic setrd(input int k, input int a);
    bus.raddr[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    idle();
    bus.raddr = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
    setrd(0, 5); setrd(1, 9);
    #1;
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_rbusy", bus.rbusy, 2'b00);
    chk("rst_rdata", bus.rdata, 64'h0);

    // Clear sweep with a write held on entry 5 throughout.
    rst = 1'b0;
    bus.we0 = 1'b1; bus.waddr0 = AW'(5); bus.wdata0 = 32'hDEAD;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      chk($sformatf("sweep_ready_%0d", i), bus.ready, (i == DEPTH));
    end
    idle();
    #1;
    chk("sweep_e5", bus.rdata[0 +: XLEN], 32'h0);
    check_ports("sweep");

    // Reset mid-run.
    bus.we0 = 1'b1; bus.waddr0 = AW'(7); bus.wdata0 = 32'h1234;
    bus.rsv_valid = 1'b1; bus.rsv_addr = AW'(12);
    tick();
    idle();
    setrd(0, 7); setrd(1, 12);
    #1;
    check_ports("pre_rst");
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_ready", bus.ready, 1'b0);
    chk("midrst_rbusy", bus.rbusy, 2'b00);
    tick();
    rst = 1'b0;
    repeat (DEPTH) tick();
    chk("midrst_e7", bus.rdata[0 +: XLEN], 32'h0);
    chk("midrst_rbusy_after", bus.rbusy, 2'b00);
    check_ports("midrst");

    // Dual-write conflict on entry 3.
    bus.we0 = 1'b1; bus.waddr0 = AW'(3); bus.wdata0 = 32'hAAAA;
    bus.we1 = 1'b1; bus.waddr1 = AW'(3); bus.wdata1 = 32'h5555;
    tick();
    idle();
    setrd(0, 3);
    #1;
    chk("conflict_e3", bus.rdata[0 +: XLEN], 32'h5555);
    check_ports("conflict");

    // Zero register.
    bus.we0 = 1'b1; bus.waddr0 = '0; bus.wdata0 = 32'hFFFF_FFFF;
    bus.rsv_valid = 1'b1; bus.rsv_addr = '0;
    setrd(0, 0); setrd(1, 0);
    #1;
    check_ports("zero_same");
    tick();
    idle();
    #1;
    chk("zero_rdata", bus.rdata[0 +: XLEN], 32'h0);
    chk("zero_rbusy", bus.rbusy[0], 1'b0);

    // Scoreboard: reservation wins over a same-cycle writeback.
    setrd(0, 9); setrd(1, 9);
    bus.rsv_valid = 1'b1; bus.rsv_addr = AW'(9);
    tick();
    chk("sb_set", bus.rbusy[0], 1'b1);
    bus.we0 = 1'b1; bus.waddr0 = AW'(9); bus.wdata0 = 32'h99;
    #1;
    check_ports("sb_both_pre");
    tick();
    idle();
    #1;
    chk("sb_stay", bus.rbusy[0], 1'b1);
    bus.we1 = 1'b1; bus.waddr1 = AW'(9); bus.wdata1 = 32'h77;
    #1;
    check_ports("sb_wr_pre");
    tick();
    idle();
    #1;
    chk("sb_clear", bus.rbusy[0], 1'b0);
    chk("sb_data", bus.rdata[0 +: XLEN], 32'h77);

    // Forwarding behaviour on entry 4.
    bus.we0 = 1'b1; bus.waddr0 = AW'(4); bus.wdata0 = 32'h1111;
    tick();
    idle();
    bus.we1 = 1'b1; bus.waddr1 = AW'(4); bus.wdata1 = 32'hCAFE;
    setrd(0, 4); setrd(1, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same", bus.rdata[0 +: XLEN], 32'hCAFE);
`else
    chk("bypass_same", bus.rdata[0 +: XLEN], 32'h1111);
`endif
    tick();
    idle();
    #1;
    chk("bypass_next", bus.rdata[0 +: XLEN], 32'hCAFE);

    // Randomized traffic, concentrated on a few entries to provoke collisions.
    for (int it = 0; it < 400; it++) begin
      int hot;
      hot = $urandom_range(0, 1);
      bus.we0 = 1'($urandom_range(0, 1));
      bus.we1 = 1'($urandom_range(0, 1));
      bus.rsv_valid = 1'($urandom_range(0, 1));
      bus.waddr0 = AW'(hot != 0 ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
      bus.waddr1 = AW'(hot != 0 ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
      bus.rsv_addr = AW'(hot != 0 ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
      bus.wdata0 = $urandom;
      bus.wdata1 = $urandom;
      for (int k = 0; k < NRD; k++) begin
        case ($urandom_range(0, 3))
          0: setrd(k, int'(bus.waddr0));
          1: setrd(k, int'(bus.waddr1));
          2: setrd(k, int'(bus.rsv_addr));
          default: setrd(k, $urandom_range(0, DEPTH - 1));
        endcase
      end
      #1;
      check_ports("rand");
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
